// File: rtl/pipe_hold_if.sv
// -----------------------------------------------------------------------------
// pipe_hold_if
// Bundles the hold-request inputs and the hold/stall/redirect outputs of the
// central pipeline controller.
//
// Signals:
//   jump_flag_i   ex stage redirects the PC this cycle
//   jump_addr_i   redirect target
//   int_hold_i    clint requests a hold for interrupt entry
//   div_busy_i    ex multi-cycle op in progress
//   load_use_i    id instruction depends on the load in ex
//   rib_hold_i    bus arbiter hold (fetch starved)
//   hold_flag_o   0=None 1=Pc 2=If 3=Id
//   stall_flag_o  freeze id_ex contents
//   jump_flag_o   redirect request to pc_reg
//   jump_addr_o   redirect target to pc_reg (0 when no redirect)
//   state_o       controller state (debug)
//   stall_cnt_o   saturating count of stall cycles
//
// Modports:
//   master  the pipeline side: drives requests, receives control
//   slave   the controller: receives requests, drives control
// -----------------------------------------------------------------------------
interface pipe_hold_if #(
  parameter int CNT_W = 16
);
  logic             jump_flag_i;
  logic [31:0]      jump_addr_i;
  logic             int_hold_i;
  logic             div_busy_i;
  logic             load_use_i;
  logic             rib_hold_i;
  logic [2:0]       hold_flag_o;
  logic             stall_flag_o;
  logic             jump_flag_o;
  logic [31:0]      jump_addr_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output jump_flag_i, jump_addr_i, int_hold_i, div_busy_i, load_use_i, rib_hold_i,
    input  hold_flag_o, stall_flag_o, jump_flag_o, jump_addr_o, state_o, stall_cnt_o
  );

  modport slave (
    input  jump_flag_i, jump_addr_i, int_hold_i, div_busy_i, load_use_i, rib_hold_i,
    output hold_flag_o, stall_flag_o, jump_flag_o, jump_addr_o, state_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_hold_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hold_ctrl
// Central pipeline control. Arbitrates the hold sources (ex jump, interrupt
// hold, multi-cycle ex busy, load-use hazard, bus hold) into the hold/stall
// flags of the pc, if_id and id_ex registers. A small FSM stretches a jump
// flush over FLUSH_CYCLES cycles and guarantees a single bubble per load-use
// hazard. A saturating counter tracks cycles spent stalled.
//
// Parameters:
//   FLUSH_CYCLES  cycles of Hold_Id per jump, including the jump cycle (1..4)
//   CNT_W         width of the stall-cycle counter
//
// Ports:
//   clk   clock
//   rst   synchronous reset, active-high; forces every output to 0
//   bus   pipe_hold_if.slave (requests in, hold/stall/redirect out)
//
// All control outputs are combinational from the registered state and the
// current requests so the pipeline reacts in the same cycle.
// -----------------------------------------------------------------------------
module pipe_hold_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  pipe_hold_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_LU_GUARD = 2'd2,
    ST_BUSY     = 2'd3
  } state_e;

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  // The jump cycle itself is the first flush cycle, so FLUSH covers the rest.
  localparam logic [2:0]       FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           r_state;
  logic [2:0]       r_flush_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  state_e           w_state_nxt;
  logic [2:0]       w_flush_cnt_nxt;
  logic [CNT_W-1:0] w_stall_cnt_nxt;
  logic [2:0]       w_hold;
  logic             w_stall;
  logic             w_jump;
  logic [31:0]      w_jump_addr;

  // Priority arbitration of hold sources and next-state selection.
  always_comb begin
    w_hold          = HOLD_NONE;
    w_stall         = 1'b0;
    w_jump          = 1'b0;
    w_jump_addr     = 32'd0;
    w_state_nxt     = ST_IDLE;
    w_flush_cnt_nxt = 3'd0;

    if (rst) begin
      w_state_nxt     = ST_IDLE;
      w_flush_cnt_nxt = 3'd0;
    end else if (bus.jump_flag_i) begin
      // A jump beats everything, including a busy divider; a jump inside
      // FLUSH restarts the flush window for the new target.
      w_jump      = 1'b1;
      w_jump_addr = bus.jump_addr_i;
      w_hold      = HOLD_ID;
      if (FLUSH_CYCLES > 1) begin
        w_state_nxt     = ST_FLUSH;
        w_flush_cnt_nxt = FLUSH_RELOAD;
      end else begin
        w_state_nxt     = ST_IDLE;
        w_flush_cnt_nxt = 3'd0;
      end
    end else if (r_state == ST_FLUSH) begin
      // Flushed stages carry no valid ops, so other requests are ignored here.
      w_hold = HOLD_ID;
      if (r_flush_cnt <= 3'd1) begin
        w_state_nxt     = ST_IDLE;
        w_flush_cnt_nxt = 3'd0;
      end else begin
        w_state_nxt     = ST_FLUSH;
        w_flush_cnt_nxt = r_flush_cnt - 3'd1;
      end
    end else if (bus.int_hold_i) begin
      // Interrupt hold keeps the state, except that the load-use guard is a
      // strict one-cycle window and always expires.
      w_hold = HOLD_ID;
      if (r_state == ST_LU_GUARD) begin
        w_state_nxt = ST_IDLE;
      end else begin
        w_state_nxt = r_state;
      end
    end else if (bus.div_busy_i) begin
      w_hold      = HOLD_ID;
      w_stall     = 1'b1;
      w_state_nxt = ST_BUSY;
    end else if (bus.load_use_i && (r_state != ST_LU_GUARD)) begin
      // One bubble into id_ex; the guard masks a stale repeat of the hazard.
      w_hold      = HOLD_ID;
      w_state_nxt = ST_LU_GUARD;
    end else if (bus.rib_hold_i) begin
      w_hold      = HOLD_PC;
      w_state_nxt = ST_IDLE;
    end else begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Saturating stall-cycle counter next value.
  always_comb begin
    w_stall_cnt_nxt = r_stall_cnt;
    if (w_stall && (r_stall_cnt != CNT_MAX)) begin
      w_stall_cnt_nxt = r_stall_cnt + CNT_ONE;
    end else begin
      w_stall_cnt_nxt = r_stall_cnt;
    end
  end

  // State, flush counter and stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= 3'd0;
      r_stall_cnt <= {CNT_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  // Every output reads as zero while reset is asserted.
  assign bus.hold_flag_o  = w_hold;
  assign bus.stall_flag_o = w_stall;
  assign bus.jump_flag_o  = w_jump;
  assign bus.jump_addr_o  = w_jump_addr;
  assign bus.state_o      = rst ? 2'd0 : r_state;
  assign bus.stall_cnt_o  = rst ? {CNT_W{1'b0}} : r_stall_cnt;

endmodule

// File: doc/pipe_hold_ctrl.md
Name: pipe_hold_ctrl

Overview:
- Central pipeline control block. Drives the hold_flag and stall_flag inputs of every pipeline register (pc, if_id, id_ex).
- Arbitrates the pipeline's hold sources: ex-stage jumps, interrupt hold, multi-cycle ex busy, load-use hazards and bus hold.
- Holds a small FSM that stretches jump flushes over FLUSH_CYCLES cycles and guarantees exactly one bubble per load-use hazard.
- Also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
FLUSH_CYCLES, 1, cycles hold_flag_o stays Hold_Id per jump, counting the jump cycle; legal 1..4
CNT_W, 16, width of stall_cnt_o

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
jump_flag_i  in  1  ex stage redirects the PC this cycle
jump_addr_i  in  32  redirect target
int_hold_i  in  1  clint requests a pipeline hold for interrupt entry
div_busy_i  in  1  ex multi-cycle op in progress
load_use_i  in  1  id instruction depends on the load currently in ex
rib_hold_i  in  1  bus arbiter hold (fetch starved)
hold_flag_o  out  3  0=Hold_None, 1=Hold_Pc, 2=Hold_If, 3=Hold_Id
stall_flag_o  out  1  freeze id_ex contents; takes priority over flush in id_ex
jump_flag_o  out  1  to pc_reg
jump_addr_o  out  32  to pc_reg
state_o  out  2  0=IDLE, 1=FLUSH, 2=LU_GUARD, 3=BUSY (debug)
stall_cnt_o  out  CNT_W  saturating count of cycles with stall_flag_o=1

Behaviour:
- Outputs are combinational from the registered state and the current inputs, giving zero-latency response. state, flush_cnt and stall_cnt update on posedge clk.
- Reset (rst=1 at a clock edge): state=IDLE, flush_cnt=0, stall_cnt=0.
  - Reset has priority over every input in that cycle.
  - While rst=1, all outputs are forced to 0: hold_flag_o=Hold_None, stall_flag_o=0, jump_flag_o=0, jump_addr_o=0.
  - Reset taken mid-flush or mid-busy returns to IDLE with no residual hold.
- Output priority when not in reset, highest first:
  1. jump_flag_i=1: jump_flag_o=1, jump_addr_o=jump_addr_i, hold_flag_o=Hold_Id, stall_flag_o=0.
     - Wins even over div_busy_i.
     - If FLUSH_CYCLES>1, next state is FLUSH with flush_cnt=FLUSH_CYCLES-1, otherwise IDLE.
  2. state=FLUSH: hold_flag_o=Hold_Id, stall_flag_o=0.
     - flush_cnt decrements each cycle; go to IDLE when flush_cnt reaches 1 at the clock edge.
     - int_hold_i, div_busy_i and load_use_i are ignored while in FLUSH, because the flushed stages hold no valid ops.
  3. int_hold_i=1: hold_flag_o=Hold_Id, stall_flag_o=0. State unchanged.
  4. div_busy_i=1: hold_flag_o=Hold_Id, stall_flag_o=1, next state BUSY.
     - When div_busy_i falls, stall_flag_o=0 in that same cycle and next state is IDLE.
  5. load_use_i=1 and state!=LU_GUARD: hold_flag_o=Hold_Id, stall_flag_o=0 (inserts one bubble into id_ex), next state LU_GUARD.
  6. rib_hold_i=1: hold_flag_o=Hold_Pc.
  7. Otherwise all outputs 0.
- LU_GUARD lasts exactly one cycle, then returns to IDLE.
  - load_use_i is masked during LU_GUARD, so one hazard produces exactly one bubble even if the id stage keeps load_use_i high for a stale cycle.
  - Higher-priority sources are still honoured in LU_GUARD.
- Whenever jump_flag_o=0, jump_addr_o is 0.
- stall_cnt increments when stall_flag_o=1 and rst=0. It saturates at all-ones with no wrap.
- Simultaneous jump_flag_i and div_busy_i: the jump wins, and BUSY is not entered in that cycle.
- A jump while already in FLUSH reloads flush_cnt=FLUSH_CYCLES-1 and forwards the new address.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all inputs driven to 1 -> all outputs 0, state_o=0, stall_cnt_o=0; after release, outputs track the inputs on the next cycle.
- Jump with FLUSH_CYCLES=3: pulse jump_flag_i=1 for 1 cycle with jump_addr_i=0x0000_0100 -> jump_flag_o=1 and jump_addr_o=0x100 in that cycle; hold_flag_o=3 for exactly 3 cycles; then 0 with state_o=0.
- Load-use: hold load_use_i=1 for 2 consecutive cycles -> hold_flag_o=3 in cycle 1 only, 0 in cycle 2 (state_o=2); back to IDLE afterwards.
- Div busy: hold div_busy_i=1 for 5 cycles -> stall_flag_o=1 and hold_flag_o=3 for 5 cycles; stall_cnt_o=5; next cycle all outputs 0. With CNT_W=3, 10 busy cycles -> stall_cnt_o=7.
- Priority collision: jump_flag_i, div_busy_i, load_use_i and rib_hold_i all 1 in one cycle -> jump_flag_o=1, hold_flag_o=3, stall_flag_o=0, stall_cnt unchanged.
- Reset mid-flush (FLUSH_CYCLES=4): jump, then rst=1 on the 2nd cycle -> outputs 0 while rst=1; after release with idle inputs, hold_flag_o=0 and state_o=0.
